change_dispenser: RTL and testbench

- Pays out the change owed by the vending FSM as a sequence of single-coin requests to a coin hopper (quarter, dime or nickel).
- Selection is greedy: largest available coin first. A per-denomination inventory is tracked.
- Sits downstream of vending_FSM. It takes the change total in binary cents and exposes the unpaid remainder for the bin2bcd/sseg display path, plus low-coin flags for the LEDs.

---
 rtl/change_pkg.sv | 37 +++
 rtl/coin_inventory.sv | 48 ++++
 rtl/change_dispenser.sv | 197 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/change_pkg.sv
// rtl/change_pkg.sv - shared states, coin/fault encodings and coin values for the change dispenser
package change_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SELECT,
    S_REQ,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_25   = 2'b11;

  localparam int VAL_5  = 5;
  localparam int VAL_10 = 10;
  localparam int VAL_25 = 25;

  localparam logic [1:0] FC_NONE   = 2'b00;
  localparam logic [1:0] FC_AMOUNT = 2'b01;
  localparam logic [1:0] FC_SHORT  = 2'b10;
  localparam logic [1:0] FC_JAM    = 2'b11;

  function automatic logic [4:0] coin_value(input logic [1:0] sel);
    case (sel)
      COIN_25: coin_value = 5'(VAL_25);
      COIN_10: coin_value = 5'(VAL_10);
      COIN_5:  coin_value = 5'(VAL_5);
      default: coin_value = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// rtl/coin_inventory.sv - per-denomination coin counters with restock load; only built with CHANGE_INVENTORY_EN
`ifdef CHANGE_INVENTORY_EN
module coin_inventory #(
  parameter int INV_W    = 4,
  parameter int N25_INIT = 8,
  parameter int N10_INIT = 8,
  parameter int N5_INIT  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic restock,
  input  logic dec_25,
  input  logic dec_10,
  input  logic dec_5,
  output logic avail_25,
  output logic avail_10,
  output logic avail_5,
  output logic low_25,
  output logic low_10,
  output logic low_5
);

  logic [INV_W-1:0] cnt_25;
  logic [INV_W-1:0] cnt_10;
  logic [INV_W-1:0] cnt_5;

  // Decrements only arrive for coins reported available, so counters never wrap.
  always_ff @(posedge clk) begin
    if (reset || restock) begin
      cnt_25 <= INV_W'(N25_INIT);
      cnt_10 <= INV_W'(N10_INIT);
      cnt_5  <= INV_W'(N5_INIT);
    end else begin
      if (dec_25) cnt_25 <= cnt_25 - INV_W'(1);
      if (dec_10) cnt_10 <= cnt_10 - INV_W'(1);
      if (dec_5)  cnt_5  <= cnt_5 - INV_W'(1);
    end
  end

  assign low_25   = (cnt_25 == '0);
  assign low_10   = (cnt_10 == '0);
  assign low_5    = (cnt_5 == '0);
  assign avail_25 = !low_25;
  assign avail_10 = !low_10;
  assign avail_5  = !low_5;

endmodule
`endif

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin payout FSM driving a single-coin hopper
// CHANGE_INVENTORY_EN enables finite coin inventory, restock, low flags and short-change fault.
module change_dispenser #(
  parameter int AMT_W       = 8,
  parameter int INV_W       = 4,
  parameter int N25_INIT    = 8,
  parameter int N10_INIT    = 8,
  parameter int N5_INIT     = 8,
  parameter int ACK_TIMEOUT = 1000000,
  parameter int GAP_CYCLES  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amount,
  input  logic             hopper_ack,
  input  logic             restock,
  input  logic             fault_clr,
  output logic             eject_req,
  output logic [1:0]       coin_sel,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [AMT_W-1:0] remaining,
  output logic             low_25,
  output logic             low_10,
  output logic             low_5
);
  import change_pkg::*;

  localparam int TMR_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] remaining_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             eject_d, done_d, fault_d, busy_d;
  logic [1:0]       coin_d, code_d;
  logic             dec_25, dec_10, dec_5;
  logic             avail_25, avail_10, avail_5;

`ifdef CHANGE_INVENTORY_EN
  coin_inventory #(
    .INV_W   (INV_W),
    .N25_INIT(N25_INIT),
    .N10_INIT(N10_INIT),
    .N5_INIT (N5_INIT)
  ) u_inv (
    .clk     (clk),
    .reset   (reset),
    .restock (restock && (state_q == S_IDLE)),
    .dec_25  (dec_25),
    .dec_10  (dec_10),
    .dec_5   (dec_5),
    .avail_25(avail_25),
    .avail_10(avail_10),
    .avail_5 (avail_5),
    .low_25  (low_25),
    .low_10  (low_10),
    .low_5   (low_5)
  );
`else
  // Unlimited supply: every coin is always available.
  localparam int unused_inv_cfg = INV_W + N25_INIT + N10_INIT + N5_INIT;
  logic unused_inv_sigs;
  assign unused_inv_sigs = ^{restock, dec_25, dec_10, dec_5};
  assign avail_25 = 1'b1;
  assign avail_10 = 1'b1;
  assign avail_5  = 1'b1;
  assign low_25   = 1'b0;
  assign low_10   = 1'b0;
  assign low_5    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      remaining  <= '0;
      timer_q    <= '0;
      eject_req  <= 1'b0;
      coin_sel   <= COIN_NONE;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      state_q    <= state_d;
      remaining  <= remaining_d;
      timer_q    <= timer_d;
      eject_req  <= eject_d;
      coin_sel   <= coin_d;
      busy       <= busy_d;
      done       <= done_d;
      fault      <= fault_d;
      fault_code <= code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining;
    timer_d     = timer_q;
    eject_d     = eject_req;
    coin_d      = coin_sel;
    done_d      = 1'b0;
    fault_d     = fault;
    code_d      = fault_code;
    dec_25      = 1'b0;
    dec_10      = 1'b0;
    dec_5       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d = change_amount;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((remaining % AMT_W'(VAL_5)) != '0) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          code_d  = FC_AMOUNT;
        end else if (remaining == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        state_d = S_REQ;
        eject_d = 1'b1;
        timer_d = '0;
        if (remaining >= AMT_W'(VAL_25) && avail_25) begin
          coin_d = COIN_25;
        end else if (remaining >= AMT_W'(VAL_10) && avail_10) begin
          coin_d = COIN_10;
        end else if (avail_5) begin
          coin_d = COIN_5;
        end else begin
          state_d = S_FAULT;
          eject_d = 1'b0;
          fault_d = 1'b1;
          code_d  = FC_SHORT;
        end
      end
      S_REQ: begin
        if (hopper_ack && eject_req) begin
          remaining_d = remaining - AMT_W'(coin_value(coin_sel));
          dec_25      = (coin_sel == COIN_25);
          dec_10      = (coin_sel == COIN_10);
          dec_5       = (coin_sel == COIN_5);
          eject_d     = 1'b0;
          coin_d      = COIN_NONE;
          timer_d     = '0;
          state_d     = S_GAP;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          // Jammed hopper: nothing was paid, so remaining and inventory stay put.
          eject_d = 1'b0;
          coin_d  = COIN_NONE;
          timer_d = '0;
          fault_d = 1'b1;
          code_d  = FC_JAM;
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_GAP: begin
        if (timer_q == TMR_W'(GAP_CYCLES - 1)) begin
          timer_d = '0;
          if (remaining == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SELECT;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      S_FAULT: begin
        if (fault_clr) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
          code_d  = FC_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CHECK) || (state_d == S_SELECT) ||
             (state_d == S_REQ) || (state_d == S_GAP);
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - scoreboard bench for change_dispenser (works with or without CHANGE_INVENTORY_EN)
module tb_change_dispenser;

  localparam int N25 = 2;
  localparam int N10 = 3;
  localparam int N5  = 1;
  localparam int ACK_TO = 50;
  localparam int GAP = 4;

  localparam logic [1:0] Q = 2'b11, D = 2'b10, N = 2'b01;
  localparam logic [1:0] C_OK = 2'b00, C_AMT = 2'b01, C_SHORT = 2'b10, C_JAM = 2'b11;

  logic       clk, reset, start, hopper_ack, restock, fault_clr;
  logic [7:0] change_amount;
  logic       eject_req, busy, done, fault, low_25, low_10, low_5;
  logic [1:0] coin_sel, fault_code;
  logic [7:0] remaining;

  int tests = 0;
  int fails = 0;

  logic [1:0] exp_q[$];
  logic [1:0] exp_code;
  logic [7:0] exp_rem;
  int m25 = N25, m10 = N10, m5 = N5;
  int r_end_cyc, r_first_ej, r_ej_cycles;

  change_dispenser #(
    .AMT_W(8), .INV_W(4), .N25_INIT(N25), .N10_INIT(N10), .N5_INIT(N5),
    .ACK_TIMEOUT(ACK_TO), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .change_amount(change_amount),
    .hopper_ack(hopper_ack), .restock(restock), .fault_clr(fault_clr),
    .eject_req(eject_req), .coin_sel(coin_sel), .busy(busy), .done(done),
    .fault(fault), .fault_code(fault_code), .remaining(remaining),
    .low_25(low_25), .low_10(low_10), .low_5(low_5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit has_coin(input int n);
`ifdef CHANGE_INVENTORY_EN
    return n > 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic exp_low(input int n);
`ifdef CHANGE_INVENTORY_EN
    return n == 0;
`else
    return 1'b0;
`endif
  endfunction

  // Greedy reference: fills exp_q with the coin sequence and sets the end outcome.
  task automatic model_payout(input logic [7:0] amt);
    int rem;
    rem = amt;
    exp_q.delete();
    exp_code = C_OK;
    if (rem % 5 != 0) exp_code = C_AMT;
    else begin
      while (rem > 0) begin
        if (rem >= 25 && has_coin(m25)) begin exp_q.push_back(Q); rem -= 25; m25--; end
        else if (rem >= 10 && has_coin(m10)) begin exp_q.push_back(D); rem -= 10; m10--; end
        else if (has_coin(m5)) begin exp_q.push_back(N); rem -= 5; m5--; end
        else begin exp_code = C_SHORT; break; end
      end
    end
    exp_rem = 8'(rem);
  endtask

  task automatic run_payout(input logic [7:0] amt, input bit ack_on, input bit noise, input bit with_restock);
    int cyc, age;
    bit ended;
    logic [1:0] exp_coin;
    @(negedge clk);
`ifdef CHANGE_INVENTORY_EN
    if (with_restock) begin m25 = N25; m10 = N10; m5 = N5; end
`endif
    if (ack_on) model_payout(amt);
    else begin exp_q.delete(); exp_code = C_JAM; exp_rem = amt; end
    start = 1'b1; change_amount = amt; restock = with_restock;
    cyc = 0; age = 0; ended = 1'b0;
    r_first_ej = -1; r_ej_cycles = 0;
    while (!ended && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; restock = 1'b0; hopper_ack = 1'b0;
      if (done || fault) ended = 1'b1;
      else begin
        if (eject_req) begin
          r_ej_cycles++;
          if (r_first_ej < 0) r_first_ej = cyc;
          age++;
          if (ack_on && age == 2) begin
            tests++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL coin_extra amt=%0d: coin_sel=%b requested, none expected", amt, coin_sel);
            end else begin
              exp_coin = exp_q.pop_front();
              if (coin_sel !== exp_coin) begin
                fails++;
                $display("FAIL coin_order amt=%0d: coin_sel=%b expected %b", amt, coin_sel, exp_coin);
              end
            end
            hopper_ack = 1'b1;
            age = 0;
          end
        end else begin
          age = 0;
          // Stray acks and start pulses while busy must be ignored.
          if (noise && busy) hopper_ack = 1'($urandom_range(0, 1));
        end
        if (noise && busy) begin
          start = 1'b1;
          change_amount = 8'($urandom_range(0, 255));
        end
      end
    end
    r_end_cyc = cyc;
    start = 1'b0; hopper_ack = 1'b0;
    tests++;
    if (!ended) begin
      fails++;
      $display("FAIL end_timeout amt=%0d: no done/fault within %0d cycles", amt, cyc);
      return;
    end
    tests++;
    if (done !== (exp_code == C_OK) || fault !== (exp_code != C_OK) || fault_code !== exp_code) begin
      fails++;
      $display("FAIL outcome amt=%0d: done=%b fault=%b code=%b expected code %b", amt, done, fault, fault_code, exp_code);
    end
    tests++;
    if (remaining !== exp_rem) begin
      fails++;
      $display("FAIL remaining amt=%0d: remaining=%0d expected %0d", amt, remaining, exp_rem);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL coins_missing amt=%0d: %0d expected coins never requested", amt, exp_q.size());
    end
    tests++;
    if (low_25 !== exp_low(m25) || low_10 !== exp_low(m10) || low_5 !== exp_low(m5)) begin
      fails++;
      $display("FAIL low_flags amt=%0d: low=%b%b%b expected %b%b%b", amt, low_25, low_10, low_5,
               exp_low(m25), exp_low(m10), exp_low(m5));
    end
`ifdef CHANGE_INVENTORY_EN
    tests++;
    if (int'(dut.u_inv.cnt_25) != m25 || int'(dut.u_inv.cnt_10) != m10 || int'(dut.u_inv.cnt_5) != m5) begin
      fails++;
      $display("FAIL inventory amt=%0d: %0d/%0d/%0d expected %0d/%0d/%0d", amt, dut.u_inv.cnt_25,
               dut.u_inv.cnt_10, dut.u_inv.cnt_5, m25, m10, m5);
    end
`endif
    if (fault) begin
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      tests++;
      if (fault !== 1'b0 || fault_code !== C_OK || remaining !== exp_rem || busy !== 1'b0) begin
        fails++;
        $display("FAIL fault_clr amt=%0d: fault=%b code=%b remaining=%0d busy=%b expected 0/00/%0d/0",
                 amt, fault, fault_code, remaining, busy, exp_rem);
      end
    end else begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL done_pulse amt=%0d: done=%b busy=%b one cycle after done, expected 0/0", amt, done, busy);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; change_amount = '0; hopper_ack = 1'b0; restock = 1'b0; fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({eject_req, coin_sel, busy, done, fault, fault_code} !== 8'd0) begin
      fails++;
      $display("FAIL reset_ctrl: eject=%b sel=%b busy=%b done=%b fault=%b code=%b expected all 0",
               eject_req, coin_sel, busy, done, fault, fault_code);
    end
    tests++;
    if (remaining !== 8'd0 || {low_25, low_10, low_5} !== 3'b000) begin
      fails++;
      $display("FAIL reset_data: remaining=%0d low=%b%b%b expected 0 and 000", remaining, low_25, low_10, low_5);
    end
    reset = 1'b0;
  endtask

  task automatic test_greedy;
    run_payout(8'd40, 1'b1, 1'b0, 1'b0);
    tests++;
    if (r_first_ej != 3) begin
      fails++;
      $display("FAIL req_latency: eject_req first high at t+%0d expected t+3", r_first_ej);
    end
  endtask

  task automatic test_short_change;
    run_payout(8'd30, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_bad_amount;
    run_payout(8'd17, 1'b1, 1'b0, 1'b0);
    tests++;
    if (r_end_cyc != 2 || r_ej_cycles != 0) begin
      fails++;
      $display("FAIL bad_amount_timing: fault at t+%0d with %0d eject cycles, expected t+2 and 0", r_end_cyc, r_ej_cycles);
    end
  endtask

  task automatic test_jam;
    run_payout(8'd25, 1'b0, 1'b0, 1'b1);
    tests++;
    if (r_ej_cycles != ACK_TO) begin
      fails++;
      $display("FAIL jam_timeout: eject_req high %0d cycles expected %0d", r_ej_cycles, ACK_TO);
    end
  endtask

  task automatic test_zero;
    run_payout(8'd0, 1'b1, 1'b0, 1'b0);
    tests++;
    if (r_end_cyc != 2 || r_ej_cycles != 0) begin
      fails++;
      $display("FAIL zero_timing: done at t+%0d with %0d eject cycles, expected t+2 and 0", r_end_cyc, r_ej_cycles);
    end
  endtask

  task automatic test_back_to_back;
    run_payout(8'd65, 1'b1, 1'b1, 1'b0);
    run_payout(8'd75, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_req;
    int cyc;
    @(negedge clk);
    start = 1'b1; change_amount = 8'd40;
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end while (!eject_req && cyc < 20);
    tests++;
    if (!eject_req) begin
      fails++;
      $display("FAIL mid_req_setup: eject_req=%b after %0d cycles expected 1", eject_req, cyc);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m25 = N25; m10 = N10; m5 = N5;
    tests++;
    if (eject_req !== 1'b0 || coin_sel !== 2'b00 || busy !== 1'b0 || remaining !== 8'd0 ||
        {low_25, low_10, low_5} !== 3'b000) begin
      fails++;
      $display("FAIL mid_req_reset: eject=%b sel=%b busy=%b remaining=%0d low=%b%b%b expected 0/00/0/0/000",
               eject_req, coin_sel, busy, remaining, low_25, low_10, low_5);
    end
`ifdef CHANGE_INVENTORY_EN
    tests++;
    if (int'(dut.u_inv.cnt_25) != N25 || int'(dut.u_inv.cnt_10) != N10 || int'(dut.u_inv.cnt_5) != N5) begin
      fails++;
      $display("FAIL mid_req_inventory: %0d/%0d/%0d expected %0d/%0d/%0d", dut.u_inv.cnt_25,
               dut.u_inv.cnt_10, dut.u_inv.cnt_5, N25, N10, N5);
    end
`endif
    run_payout(8'd10, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_greedy;
    test_short_change;
    test_bad_amount;
    test_jam;
    test_zero;
    test_back_to_back;
    test_reset_mid_req;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
